sumador_serie_mpc: RTL and testbench



---
 rtl/sumador_serie_mpc_pkg.sv | 25 ++
 rtl/sumador_serie_mpc_if.sv | 31 +++
 rtl/sumador_serie_mpc_completo.sv | 28 ++
 rtl/sumador_serie_mpc.sv | 144 ++++++++++++++
 tb/tb_sumador_serie_mpc.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/sumador_serie_mpc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sumador_pkg
// Purpose : FSM state encoding, mode constants and half-adder helper shared by
//           the serial adder.
// Revision: 1.0 - initial release
// ============================================================================
package sumador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  // Half adder: returns {carry, sum}.
  function automatic logic [1:0] semi_sumador(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sumador_serie_mpc_if.sv
`default_nettype none
// ============================================================================
// Module  : sumador_serie_mpc_if
// Purpose : Request/result bundle of the serial adder. The modo port only
//           exists when MODO_RESTA_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
interface sumador_serie_mpc_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
`ifdef MODO_RESTA_EN
  logic         modo;
`endif
  logic         busy;
  logic         done;
  logic [N-1:0] s;
  logic         c_out;

`ifdef MODO_RESTA_EN
  modport master (output start, a, b, modo, input  busy, done, s, c_out);
  modport slave  (input  start, a, b, modo, output busy, done, s, c_out);
`else
  modport master (output start, a, b, input  busy, done, s, c_out);
  modport slave  (input  start, a, b, output busy, done, s, c_out);
`endif

endinterface
`default_nettype wire

// File: rtl/sumador_serie_mpc_completo.sv
`default_nettype none
// ============================================================================
// Module  : sumador_completo
// Purpose : Combinational full adder assembled from two half-adder stages.
// Revision: 1.0 - initial release
// ============================================================================
module sumador_completo
  import sumador_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic [1:0] w_h1;
  logic [1:0] w_h2;

  always_comb begin
    w_h1 = semi_sumador(x, y);
    w_h2 = semi_sumador(w_h1[0], cin);
    s    = w_h2[0];
    cout = w_h1[1] | w_h2[1];
  end

endmodule
`default_nettype wire

// File: rtl/sumador_serie_mpc.sv
`default_nettype none
// ============================================================================
// Module  : sumador_serie_mpc
// Purpose : Bit-serial N-bit adder, LSB first through one full-adder cell.
//           Define MODO_RESTA_EN to add the modo input (subtract with borrow).
// Revision: 1.0 - initial release
// ============================================================================
module sumador_serie_mpc
  import sumador_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  sumador_serie_mpc_if.slave    bus
);

  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  res_q, res_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N-1:0]  s_q, s_d;
  logic          c_out_q, c_out_d;
`ifdef MODO_RESTA_EN
  logic          mode_q, mode_d;
`endif

  logic fa_s;
  logic fa_cout;

  sumador_completo u_fa (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    s_d     = s_q;
    c_out_d = c_out_q;
`ifdef MODO_RESTA_EN
    mode_d  = mode_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = ADD;
          cnt_d   = '0;
`ifdef MODO_RESTA_EN
          mode_d  = bus.modo;
          // Two's-complement subtraction: invert B and inject a carry of one.
          if (bus.modo == SUB) begin
            b_d     = ~bus.b;
            carry_d = 1'b1;
          end
`endif
        end
      end
      SHIFT: begin
        a_d     = {1'b0, a_q[N-1:1]};
        b_d     = {1'b0, b_q[N-1:1]};
        res_d   = {fa_s, res_q[N-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        s_d     = res_q;
        done_d  = 1'b1;
        state_d = IDLE;
`ifdef MODO_RESTA_EN
        c_out_d = (mode_q == SUB) ? ~carry_q : carry_q;
`else
        c_out_d = carry_q;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      c_out_q <= 1'b0;
`ifdef MODO_RESTA_EN
      mode_q  <= ADD;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      s_q     <= s_d;
      c_out_q <= c_out_d;
`ifdef MODO_RESTA_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.s     = s_q;
  assign bus.c_out = c_out_q;

endmodule
`default_nettype wire

// File: tb/tb_sumador_serie_mpc.sv
`default_nettype none
// ============================================================================
// Module  : tb_sumador_serie_mpc
// Purpose : Directed and random checks of the serial adder with a result queue.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sumador_serie_mpc;

  localparam int N = 8;

  typedef struct packed {
    logic [N-1:0] s;
    logic         c;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t sb[$];

  sumador_serie_mpc_if #(.N(N)) bus ();

  sumador_serie_mpc #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y, input logic m);
    exp_t     e;
    logic [N:0] t;
    if (m) begin
      e.s = x - y;
      e.c = (x < y);
    end else begin
      t   = {1'b0, x} + {1'b0, y};
      e.s = t[N-1:0];
      e.c = t[N];
    end
    return e;
  endfunction

  // inject: 0 = none, 1 = second start on SHIFT cycle 3, 2 = reset on SHIFT cycle 4
  task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tbv,
                       input logic tm, input int inject, input string tag);
    exp_t e;
    int   cyc;
    int   nbusy;
    int   ndone;
    bit   aborted;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tbv;
`ifdef MODO_RESTA_EN
    bus.modo  = tm;
`endif
    sb.push_back(model(ta, tbv, tm));
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = ~ta;
    bus.b     = ~tbv;
`ifdef MODO_RESTA_EN
    bus.modo  = ~tm;
`endif
    cyc     = 0;
    nbusy   = 0;
    aborted = 0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      if (bus.busy === 1'b1) nbusy++;
      if (inject == 1 && cyc == 3) begin
        bus.start = 1'b1;
        bus.a     = 8'h33;
        bus.b     = 8'h44;
      end
      if (inject == 2 && cyc == 4) rst = 1'b1;
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      if (inject == 2 && cyc == 5) begin
        check({tag, "_abort_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_abort_s"},    32'(bus.s),    32'd0);
        check({tag, "_abort_done"}, 32'(bus.done), 32'd0);
        rst = 1'b0;
        void'(sb.pop_back());
        aborted = 1;
        break;
      end
    end
    if (aborted) begin
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (bus.done === 1'b1) ndone++;
      end
      check({tag, "_abort_nodone"}, 32'(ndone), 32'd0);
    end else begin
      check({tag, "_done_seen"}, 32'(bus.done), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({tag, "_s"},     32'(bus.s),     32'(e.s));
        check({tag, "_c_out"}, 32'(bus.c_out), 32'(e.c));
      end else begin
        check({tag, "_scoreboard_empty"}, 32'(sb.size()), 32'd1);
      end
      check({tag, "_latency"}, 32'(cyc),   32'(N + 1));
      check({tag, "_busy_cycles"}, 32'(nbusy), 32'(N));
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
      if (inject == 1) begin
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
          @(negedge clk);
          if (bus.done === 1'b1) ndone++;
        end
        check({tag, "_no_extra_done"}, 32'(ndone), 32'd0);
      end
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
`ifdef MODO_RESTA_EN
    bus.modo  = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_busy",  32'(bus.busy),  32'd0);
      check("rst_done",  32'(bus.done),  32'd0);
      check("rst_s",     32'(bus.s),     32'd0);
      check("rst_c_out", 32'(bus.c_out), 32'd0);
    end

    do_op(8'h0F, 8'h01, 1'b0, 0, "add_0f_01");
    do_op(8'hFF, 8'h01, 1'b0, 0, "add_ff_01");
    do_op(8'h80, 8'h80, 1'b0, 0, "add_80_80");
    do_op(8'hA5, 8'h5A, 1'b0, 0, "add_a5_5a");
    do_op(8'h12, 8'h34, 1'b0, 1, "start_ignored");
    do_op(8'h77, 8'h11, 1'b0, 2, "rst_mid");
    do_op(8'h03, 8'h04, 1'b0, 0, "after_rst");

`ifdef MODO_RESTA_EN
    do_op(8'h05, 8'h03, 1'b1, 0, "sub_05_03");
    do_op(8'h00, 8'h01, 1'b1, 0, "sub_00_01");
`endif

    for (int i = 0; i < 10; i++) begin
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      logic         rm;
      ra = N'($urandom);
      rb = N'($urandom);
`ifdef MODO_RESTA_EN
      rm = 1'(i);
`else
      rm = 1'b0;
`endif
      do_op(ra, rb, rm, 0, "random");
    end

    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
